regfile_wb: RTL

- General-purpose register file: the consumer end of the write-back interface (write enable, write address, write data) that travels down the pipeline from the EX/MEM and MEM/WB registers.
- Holds the 32 architectural MIPS registers and supplies two read ports to the ID stage.
- A same-cycle write is bypassed to the read ports, so an instruction in ID sees a result retiring in WB in the same cycle.

---
 rtl/regfile_wb.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - 31x32 MIPS general-purpose register file with write-back bypass to two read ports
module regfile_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    // r0 is hardwired to zero, so only r1..rN-1 hold state.
    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];

    // Full-range view of the array with r0 tied to zero, so read muxes index it directly.
    logic [DATA_W-1:0] rd_view [0:NUM_REGS-1];

    // A write to r0 never reaches the array: no register matches address 0.
    logic wr_valid;
    assign wr_valid = we && (waddr != '0);

    assign rd_view[0] = '0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_reg
            logic              wr_hit;
            logic [DATA_W-1:0] reg_d;

            assign wr_hit = wr_valid && (waddr == ADDR_W'(g));

            // Next-state: load write data on an address hit, otherwise hold.
            always_comb begin
                reg_d = regs_q[g];
                if (wr_hit) begin
                    reg_d = wdata;
                end
            end

            // Synchronous clear dominates any write presented in the same cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[g] <= '0;
                end else begin
                    regs_q[g] <= reg_d;
                end
            end

            assign rd_view[g] = regs_q[g];
        end
    endgenerate

    // Read port 1: reset, r0, write-first bypass, array, then disabled, in that priority.
    always_comb begin
        rdata1 = '0;
        if (rst) begin
            rdata1 = '0;
        end else if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (re1 && we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else if (re1) begin
            rdata1 = rd_view[raddr1];
        end
    end

    // Read port 2: same priority as port 1, fully independent of it.
    always_comb begin
        rdata2 = '0;
        if (rst) begin
            rdata2 = '0;
        end else if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (re2 && we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else if (re2) begin
            rdata2 = rd_view[raddr2];
        end
    end

endmodule
